// File: rtl/edge_det_flt_pkg.sv
// Shared types and default parameter values for the edge_det_flt block.
package edge_det_flt_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int STAGE_DEF     = 2;
  localparam int CH_NUM_DEF    = 8;
  localparam int FLT_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF = 8;

endpackage

// File: rtl/edge_det_flt_ch.sv
// One channel: synchroniser, glitch filter, edge detect, sticky pending flag and
// an optional saturating event counter (built only with EDGE_DET_FLT_CNT_EN).
module edge_det_flt_ch
  import edge_det_flt_pkg::*;
#(
  parameter int STAGE     = STAGE_DEF,
  parameter int FLT_WIDTH = FLT_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dat_i,
  input  logic [FLT_WIDTH-1:0] flt_thr_i,
  input  logic [1:0]           mode_i,
  input  logic                 clr_i,
  output logic                 dat_o,
  output logic                 re_o,
  output logic                 fe_o,
  output logic                 evt_o,
  output logic                 pend_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [STAGE-1:0]     sync_q;
  logic                 sync;
  logic                 filt_q;
  logic                 filt_d_q;
  logic [FLT_WIDTH-1:0] flt_cnt_q;
  logic                 pend_q;
  logic                 evt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGE-2:0], dat_i};
  end

  assign sync = sync_q[STAGE-1];

  // '>=' rather than '==' so a threshold lowered below a running count
  // commits the new level on the very next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q    <= 1'b0;
      filt_d_q  <= 1'b0;
      flt_cnt_q <= '0;
    end else begin
      filt_d_q <= filt_q;
      if (sync == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q >= flt_thr_i) begin
        filt_q    <= sync;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FLT_WIDTH'(1);
      end
    end
  end

  assign dat_o = filt_q;
  assign re_o  = filt_q & ~filt_d_q;
  assign fe_o  = ~filt_q & filt_d_q;

  always_comb begin
    // NOTE: default assignment first so no path leaves evt unassigned (no latch).
    evt = 1'b0;
    case (mode_e'(mode_i))
      MODE_RISE: evt = re_o;
      MODE_FALL: evt = fe_o;
      MODE_BOTH: evt = re_o | fe_o;
      default:   evt = 1'b0;
    endcase
  end

  assign evt_o = evt;

  // A new event outranks a simultaneous clear so it is never lost.
  always_ff @(posedge clk_i) begin
    if (rst_i)      pend_q <= 1'b0;
    else if (evt)   pend_q <= 1'b1;
    else if (clr_i) pend_q <= 1'b0;
  end

  assign pend_o = pend_q;

`ifdef EDGE_DET_FLT_CNT_EN
  logic [CNT_WIDTH-1:0] evt_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_cnt_q <= '0;
    end else if (clr_i) begin
      evt_cnt_q <= evt ? CNT_WIDTH'(1) : '0;
    end else if (evt && (evt_cnt_q != '1)) begin
      evt_cnt_q <= evt_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign cnt_o = evt_cnt_q;
`else
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/edge_det_flt.sv
// Multi-channel filtered edge detector with interrupt OR. Optional per-channel
// event counters are enabled by defining EDGE_DET_FLT_CNT_EN.
module edge_det_flt
  import edge_det_flt_pkg::*;
#(
  parameter int STAGE     = STAGE_DEF,     // 2..4
  parameter int CH_NUM    = CH_NUM_DEF,
  parameter int FLT_WIDTH = FLT_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [CH_NUM-1:0]           dat_i,
  input  logic [FLT_WIDTH-1:0]        flt_thr_i,
  input  logic [2*CH_NUM-1:0]         mode_i,
  input  logic [CH_NUM-1:0]           clr_i,
  output logic [CH_NUM-1:0]           dat_o,
  output logic [CH_NUM-1:0]           re_o,
  output logic [CH_NUM-1:0]           fe_o,
  output logic [CH_NUM-1:0]           evt_o,
  output logic [CH_NUM-1:0]           pend_o,
  output logic                        irq_o,
  output logic [CH_NUM*CNT_WIDTH-1:0] cnt_o
);

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    edge_det_flt_ch #(
      .STAGE     (STAGE),
      .FLT_WIDTH (FLT_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .dat_i     (dat_i[n]),
      .flt_thr_i (flt_thr_i),
      .mode_i    (mode_i[2*n +: 2]),
      .clr_i     (clr_i[n]),
      .dat_o     (dat_o[n]),
      .re_o      (re_o[n]),
      .fe_o      (fe_o[n]),
      .evt_o     (evt_o[n]),
      .pend_o    (pend_o[n]),
      .cnt_o     (cnt_o[n*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  assign irq_o = |pend_o;

endmodule

// File: tb/tb_edge_det_flt.sv
// Directed bench for edge_det_flt (STAGE=2, T=3, CNT_WIDTH=2); counter
// expectations follow EDGE_DET_FLT_CNT_EN.
module tb_edge_det_flt;
  import edge_det_flt_pkg::*;

  localparam int STAGE = 2;
  localparam int CH    = 8;
  localparam int FW    = 4;
  localparam int CW    = 2;
`ifdef EDGE_DET_FLT_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic [CH-1:0]     dat_i;
  logic [FW-1:0]     flt_thr_i;
  logic [2*CH-1:0]   mode_i;
  logic [CH-1:0]     clr_i;
  logic [CH-1:0]     dat_o, re_o, fe_o, evt_o, pend_o;
  logic              irq_o;
  logic [CH*CW-1:0]  cnt_o;

  int total = 0;
  int bad   = 0;
  int steps, re_n, fe_n, evt_n, re_at, fe_at;

  always #5 clk = ~clk;

  edge_det_flt #(
    .STAGE     (STAGE),
    .CH_NUM    (CH),
    .FLT_WIDTH (FW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .dat_i     (dat_i),
    .flt_thr_i (flt_thr_i),
    .mode_i    (mode_i),
    .clr_i     (clr_i),
    .dat_o     (dat_o),
    .re_o      (re_o),
    .fe_o      (fe_o),
    .evt_o     (evt_o),
    .pend_o    (pend_o),
    .irq_o     (irq_o),
    .cnt_o     (cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    steps++;
  endtask

  task automatic clear_stats();
    steps = 0; re_n = 0; fe_n = 0; evt_n = 0; re_at = -1; fe_at = -1;
  endtask

  // Advance n cycles, tallying pulses on one channel.
  task automatic run(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (re_o[ch]) begin re_n++; if (re_at < 0) re_at = steps; end
      if (fe_o[ch]) begin fe_n++; if (fe_at < 0) fe_at = steps; end
      if (evt_o[ch]) evt_n++;
    end
  endtask

  task automatic set_mode(input int ch, input mode_e m);
    mode_i[2*ch +: 2] = m;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; dat_i = '0; flt_thr_i = 4'd3; mode_i = '0; clr_i = '0;
    clear_stats();
    step(); step();
    check("rst_dat",  32'(dat_o),  32'd0);
    check("rst_re",   32'(re_o),   32'd0);
    check("rst_pend", 32'(pend_o), 32'd0);
    check("rst_irq",  32'(irq_o),  32'd0);
    check("rst_cnt",  32'(cnt_o),  32'd0);
    rst_i = 1'b0;
    step();

    // Channel 0: clean rise, mode rise, edge at cycle STAGE+T+1 = 6.
    set_mode(0, MODE_RISE);
    clear_stats();
    dat_i[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("ch0_re",   32'(re_o[0]),   32'(k == 6));
      check("ch0_evt",  32'(evt_o[0]),  32'(k == 6));
      check("ch0_dat",  32'(dat_o[0]),  32'(k >= 6));
      check("ch0_pend", 32'(pend_o[0]), 32'(k >= 7));
    end
    check("ch0_irq", 32'(irq_o), 32'd1);
    clr_i[0] = 1'b1; step(); clr_i[0] = 1'b0;
    check("ch0_clr", 32'(pend_o[0]), 32'd0);

    // Channel 1: 3-cycle glitch rejected.
    clear_stats();
    for (int k = 1; k <= 15; k++) begin
      dat_i[1] = (k <= 3);
      step();
      check("ch1_glitch3", 32'({dat_o[1], re_o[1], fe_o[1]}), 32'd0);
    end
    // 4-cycle glitch passes: rise at 6, fall at 10.
    clear_stats();
    for (int k = 1; k <= 16; k++) begin
      dat_i[1] = (k <= 4);
      run(1, 1);
    end
    check("ch1_g4_re_n",  32'(re_n),  32'd1);
    check("ch1_g4_fe_n",  32'(fe_n),  32'd1);
    check("ch1_g4_re_at", 32'(re_at), 32'd6);
    check("ch1_g4_fe_at", 32'(fe_at), 32'd10);

    // Channel 2: mode fall, then mode off.
    set_mode(2, MODE_FALL);
    clear_stats(); dat_i[2] = 1'b1; run(2, 10);
    check("ch2_rise_re_n", 32'(re_n),      32'd1);
    check("ch2_rise_evt",  32'(evt_n),     32'd0);
    check("ch2_rise_pend", 32'(pend_o[2]), 32'd0);
    clear_stats(); dat_i[2] = 1'b0; run(2, 10);
    check("ch2_fall_fe_n", 32'(fe_n),      32'd1);
    check("ch2_fall_fe_at",32'(fe_at),     32'd6);
    check("ch2_fall_evt",  32'(evt_n),     32'd1);
    check("ch2_fall_pend", 32'(pend_o[2]), 32'd1);
    set_mode(2, MODE_OFF);
    clr_i[2] = 1'b1; step(); clr_i[2] = 1'b0;
    check("ch2_clr", 32'(pend_o[2]), 32'd0);
    clear_stats();
    dat_i[2] = 1'b1; run(2, 10);
    dat_i[2] = 1'b0; run(2, 10);
    check("ch2_off_re_n", 32'(re_n),      32'd1);
    check("ch2_off_fe_n", 32'(fe_n),      32'd1);
    check("ch2_off_evt",  32'(evt_n),     32'd0);
    check("ch2_off_pend", 32'(pend_o[2]), 32'd0);

    // Channel 3: clear coincides with event, set wins, counter loads 1.
    set_mode(3, MODE_RISE);
    clear_stats(); dat_i[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (re_o[3]) break;
    end
    check("ch3_re_step", 32'(steps), 32'd6);
    clr_i[3] = 1'b1; step(); clr_i[3] = 1'b0;
    check("ch3_pend", 32'(pend_o[3]), 32'd1);
    check("ch3_cnt",  32'(cnt_o[3*CW +: CW]), 32'(CNT_EN));

    // Channel 4: mode both, 5 events saturate the 2-bit counter at 3.
    set_mode(4, MODE_BOTH);
    clear_stats();
    for (int e = 0; e < 5; e++) begin
      dat_i[4] = ~dat_i[4];
      run(4, 8);
      if (e == 1) check("ch4_cnt2", 32'(cnt_o[4*CW +: CW]), 32'(CNT_EN * 2));
    end
    check("ch4_evt_n", 32'(evt_n), 32'd5);
    check("ch4_cnt5",  32'(cnt_o[4*CW +: CW]), 32'(CNT_EN * 3));

    // Channel 6: lowering the threshold below the running count commits at once.
    clear_stats(); dat_i[6] = 1'b1;
    repeat (4) step();
    check("ch6_before", 32'(dat_o[6]), 32'd0);
    flt_thr_i = 4'd1;
    step();
    check("ch6_after", 32'(dat_o[6]), 32'd1);
    flt_thr_i = 4'd3;
    step();

    // Channel 5: reset mid-filter (cnt=2), then genuine rise after release.
    clear_stats(); dat_i[5] = 1'b1;
    repeat (4) step();
    rst_i = 1'b1;
    step();
    check("mrst_dat",  32'(dat_o),  32'd0);
    check("mrst_re",   32'(re_o),   32'd0);
    check("mrst_fe",   32'(fe_o),   32'd0);
    check("mrst_evt",  32'(evt_o),  32'd0);
    check("mrst_pend", 32'(pend_o), 32'd0);
    check("mrst_irq",  32'(irq_o),  32'd0);
    check("mrst_cnt",  32'(cnt_o),  32'd0);
    rst_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("ch5_rel_re", 32'(re_o[5]), 32'(k == 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_det_flt.md
EDGE_DET_FLT -- requirements
Module: edge_det_flt

Interface
REQ-001 SHALL have parameter STAGE, default 2: synchroniser depth per channel, legal range 2..4.
REQ-002 SHALL have parameter CH_NUM, default 8: number of independent channels, at least 1.
REQ-003 SHALL have parameter FLT_WIDTH, default 4: glitch-filter counter and threshold width.
REQ-004 SHALL have parameter CNT_WIDTH, default 8: per-channel event-counter width.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL be clocked on the rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port dat_i, input, CH_NUM bits: asynchronous raw inputs.
REQ-008 SHALL have port flt_thr_i, input, FLT_WIDTH bits: filter threshold shared by all channels.
REQ-009 SHALL have port mode_i, input, 2*CH_NUM bits: per-channel edge mode, channel n at bits [2n+1:2n].
REQ-010 SHALL have port clr_i, input, CH_NUM bits: per-channel clear of pending flag and counter.
REQ-011 SHALL have port dat_o, output, CH_NUM bits: filtered level.
REQ-012 SHALL have ports re_o and fe_o, outputs, CH_NUM bits each: rising and falling edge pulses on filtered data, independent of mode.
REQ-013 SHALL have port evt_o, output, CH_NUM bits: mode-qualified event pulse.
REQ-014 SHALL have port pend_o, output, CH_NUM bits: sticky pending flags.
REQ-015 SHALL have port irq_o, output, 1 bit: OR of all pend_o bits.
REQ-016 SHALL have port cnt_o, output, CH_NUM*CNT_WIDTH bits: event counters, channel n at bits [n*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-017 Each channel SHALL pass dat_i through an STAGE-flop synchroniser, giving sync.
REQ-018 Filter: if sync equals filt, cnt SHALL be cleared to 0; if sync differs from filt and cnt is less than flt_thr_i, cnt SHALL increment; if sync differs from filt and cnt equals flt_thr_i, filt SHALL take the value of sync and cnt SHALL clear.
REQ-019 With flt_thr_i = T, a stable input level change SHALL appear on dat_o exactly STAGE+T+1 cycles after it is sampled; pulses of T cycles or fewer at sync SHALL be rejected.
REQ-020 Lowering flt_thr_i below the current cnt SHALL take effect on the next cycle, and the channel SHALL treat cnt as greater than or equal to the threshold, so filt updates immediately.
REQ-021 dat_o SHALL equal filt; filt_d SHALL be filt delayed by one cycle.
REQ-022 re_o SHALL equal filt AND NOT filt_d; fe_o SHALL equal NOT filt AND filt_d; each is a one-cycle pulse.
REQ-023 Mode SHALL select events as follows: 00 gives no events; 01 gives evt = re; 10 gives evt = fe; 11 gives evt = re OR fe.
REQ-024 A mode change SHALL apply combinationally to the current cycle and SHALL NOT retroactively set pend.
REQ-025 pend SHALL be set on evt and cleared on clr_i; if evt and clr_i occur in the same cycle, pend SHALL be 1 (set wins).
REQ-026 irq_o SHALL be combinational, with no additional latency.

Reset
REQ-027 While rst_i is high at a clock edge, the synchroniser, filt, filt_d, cnt, pend and counters SHALL all reset to 0, so dat_o, re_o, fe_o, evt_o, pend_o, irq_o and cnt_o are all 0.
REQ-028 A reset in mid-filter SHALL discard the partial count.
REQ-029 If dat_i is held high through reset release, the block SHALL report a genuine rising edge after STAGE+T+1 cycles.

Configuration
REQ-030 With macro EDGE_DET_FLT_CNT_EN defined, each channel SHALL have a CNT_WIDTH counter that increments on evt and saturates at all-ones.
REQ-031 With EDGE_DET_FLT_CNT_EN defined, clr_i SHALL zero the counter; if clr_i and evt occur in the same cycle, the counter SHALL load 1.
REQ-032 Without EDGE_DET_FLT_CNT_EN, cnt_o SHALL remain present, be tied to 0, and no counter flops SHALL exist.

Structure
REQ-033 Package edge_det_flt_pkg SHALL hold the mode enum (MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11) and the default parameter constants.
REQ-034 The per-channel logic (synchroniser, filter, edge, pend, counter) SHALL be one sub-module, edge_det_flt_ch, instantiated CH_NUM times in a generate loop; the top SHALL contain only slicing and the irq_o OR.

Verification
REQ-035 Bench SHALL cover: STAGE=2, T=3, channel 0 dat_i 0->1 held, mode 01 -> re_o[0] and evt_o[0] pulse once at cycle 6, pend_o[0]=1, irq_o=1.
REQ-036 Bench SHALL cover: T=3, 3-cycle high glitch on dat_i[1] -> dat_o[1], re_o[1] and fe_o[1] stay 0; a 4-cycle glitch -> one re_o pulse followed by one fe_o pulse.
REQ-037 Bench SHALL cover: mode 10 on channel 2, rising then falling input -> evt_o[2] only on the falling edge; mode 00 -> pend_o[2] never set while re_o and fe_o still pulse.
REQ-038 Bench SHALL cover: evt and clr_i[3] in the same cycle -> pend_o[3]=1, and cnt_o channel 3 = 1 with EDGE_DET_FLT_CNT_EN.
REQ-039 Bench SHALL cover: with EDGE_DET_FLT_CNT_EN, CNT_WIDTH=2 and 5 events -> counter = 3 (saturated); without the macro -> cnt_o = 0.
REQ-040 Bench SHALL cover: rst_i asserted mid-filter with cnt=2 -> all outputs 0 next cycle; input held high -> re_o after STAGE+T+1 cycles from release.
